// File: rtl/pipe_stage_buffer.sv
// rtl/pipe_stage_buffer.sv - valid/ready pipeline register with 2-entry skid buffer and flush
module pipe_stage_buffer #(
  parameter int CTRL_W     = 8,
  parameter int DATA_W     = 96,
  parameter int CLEAR_DATA = 0,
  parameter int DROP_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [DROP_W-1:0] drop_count
);

  // State doubles as the occupancy count: skid is only ever valid behind a valid main entry.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int CW = DROP_W + 2;

  state_e            state_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic          main_valid, skid_valid, accept, pop;
  logic [1:0]    drop_inc;
  logic [CW-1:0] drop_sum;
  logic [CW-1:0] drop_max;

  // in_ready comes straight from registered state, so there is no path from out_ready.
  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);
  assign in_ready   = ~skid_valid;
  assign accept     = in_valid & in_ready;
  assign pop        = main_valid & out_ready;

  assign out_valid  = main_valid;
  assign out_ctrl   = main_valid ? main_ctrl_q : '0;
  assign out_data   = main_data_q;
  assign occupancy  = state_q;
  assign drop_count = drop_q;

  // Saturating count of entries killed by a flush; a popped main entry was delivered, not dropped.
  always_comb begin
    drop_inc = 2'(main_valid & ~pop) + 2'(skid_valid) + 2'(accept);
    drop_sum = {2'b00, drop_q} + CW'(drop_inc);
    drop_max = {2'b00, {DROP_W{1'b1}}};
    drop_d   = drop_q;
    if (flush) begin
      drop_d = (drop_sum > drop_max) ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end
  end

  // Occupancy FSM and entry registers; flush overrides any handshake and leaves a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      drop_q      <= '0;
    end else begin
      drop_q <= drop_d;
      if (flush) begin
        state_q     <= EMPTY;
        main_ctrl_q <= '0;
        skid_ctrl_q <= '0;
        if (CLEAR_DATA != 0) begin
          main_data_q <= '0;
          skid_data_q <= '0;
        end
      end else begin
        case (state_q)
          EMPTY: begin
            if (accept) begin
              main_ctrl_q <= in_ctrl;
              main_data_q <= in_data;
              state_q     <= ONE;
            end
          end
          ONE: begin
            if (accept && pop) begin
              main_ctrl_q <= in_ctrl;
              main_data_q <= in_data;
            end else if (accept) begin
              skid_ctrl_q <= in_ctrl;
              skid_data_q <= in_data;
              state_q     <= FULL;
            end else if (pop) begin
              main_ctrl_q <= '0;
              state_q     <= EMPTY;
            end
          end
          FULL: begin
            if (pop) begin
              main_ctrl_q <= skid_ctrl_q;
              main_data_q <= skid_data_q;
              skid_ctrl_q <= '0;
              state_q     <= ONE;
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb/tb_pipe_stage_buffer.sv - directed and scoreboard checks for pipe_stage_buffer
module tb_pipe_stage_buffer;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [1:0]        drop_count;

  logic              w_in_ready;
  logic              w_out_valid;
  logic [CTRL_W-1:0] w_out_ctrl;
  logic [DATA_W-1:0] w_out_data;
  logic [1:0]        w_occupancy;
  logic [7:0]        w_drop_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] sb_q[$];
  logic [DATA_W-1:0] exp_d;
  logic              acc, pp;

  always #5 clk = ~clk;

  pipe_stage_buffer #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(1), .DROP_W(2)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .drop_count(drop_count)
  );

  pipe_stage_buffer #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(0), .DROP_W(8)) u_wide (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_ctrl(w_out_ctrl), .out_data(w_out_data),
    .occupancy(w_occupancy), .drop_count(w_drop_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [CTRL_W-1:0] ctrl_of(input logic [DATA_W-1:0] d);
    return {1'b1, d[6:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = ctrl_of(d);
  endtask

  task automatic fill2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    out_ready = 1'b0;
    offer(a); step();
    offer(b); step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data, 0);
    check("rst_occ", occupancy, 0);
    check("rst_drop", drop_count, 0);
    rst = 1'b0;

    // streaming 1..8 at full rate
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      offer(DATA_W'(k));
      step();
      check("stream_valid", out_valid, 1);
      check("stream_data", out_data, k);
      check("stream_ctrl", out_ctrl, ctrl_of(DATA_W'(k)));
      check("stream_occ", occupancy, 1);
      check("stream_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_valid", out_valid, 0);
    check("stream_drain_ctrl", out_ctrl, 0);
    check("stream_drain_occ", occupancy, 0);

    // stall with A,B then release
    fill2(32'hA, 32'hB);
    check("stall_occ", occupancy, 2);
    check("stall_ready", in_ready, 0);
    check("stall_data", out_data, 32'hA);
    step();
    check("stall_hold_data", out_data, 32'hA);
    check("stall_hold_ctrl", out_ctrl, ctrl_of(32'hA));
    check("stall_hold_occ", occupancy, 2);
    out_ready = 1'b1;
    step();
    check("stall_pop1_data", out_data, 32'hB);
    check("stall_pop1_ready", in_ready, 1);
    check("stall_pop1_occ", occupancy, 1);
    step();
    check("stall_pop2_valid", out_valid, 0);
    check("stall_pop2_ctrl", out_ctrl, 0);
    check("stall_pop2_occ", occupancy, 0);

    // flush at FULL with in_valid offered (not accepted): drops main+skid
    fill2(32'h11, 32'h22);
    offer(32'h33);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush1_valid", out_valid, 0);
    check("flush1_ctrl", out_ctrl, 0);
    check("flush1_occ", occupancy, 0);
    check("flush1_data_clr", out_data, 0);
    check("flush1_ready", in_ready, 1);
    check("flush1_drop", drop_count, 2);
    check("flush1_wdrop", w_drop_count, 2);

    // flush at ONE while accepting: main + accepted entry dropped
    out_ready = 1'b0;
    offer(32'h44); step();
    offer(32'h55);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush2_valid", out_valid, 0);
    check("flush2_drop_sat", drop_count, 3);
    check("flush2_wdrop", w_drop_count, 4);

    // third 2-entry flush: narrow counter stays saturated
    fill2(32'h66, 32'h77);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush3_drop_sat", drop_count, 3);
    check("flush3_wdrop", w_drop_count, 6);

    // flush at ONE while popping: delivered entry not counted
    out_ready = 1'b0;
    offer(32'h88); step();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush4_occ", occupancy, 0);
    check("flush4_wdrop", w_drop_count, 6);

    // flush while EMPTY, no accept: nothing changes
    flush = 1'b1;
    step();
    check("flush5_occ", occupancy, 0);
    check("flush5_wdrop", w_drop_count, 6);

    // flush while EMPTY with accept: accepted entry is dropped
    offer(32'h99);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush6_valid", out_valid, 0);
    check("flush6_wdrop", w_drop_count, 7);
    check("flush6_drop_sat", drop_count, 3);

    // async reset mid-stream at occupancy 2
    fill2(32'hAA, 32'hBB);
    check("mid_occ_pre", occupancy, 2);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ctrl", out_ctrl, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_occ", occupancy, 0);
    check("mid_rst_drop", drop_count, 0);
    check("mid_rst_wdrop", w_drop_count, 0);
    step();
    rst = 1'b0;

    // random valid/ready against a FIFO scoreboard
    for (int c = 0; c < 3000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      in_ctrl   = ctrl_of(in_data);
      #1;
      acc = in_valid && (sb_q.size() < 2);
      pp  = out_ready && (sb_q.size() != 0);
      if (pp) begin
        exp_d = sb_q.pop_front();
        check("sb_data", out_data, exp_d);
        check("sb_ctrl", out_ctrl, ctrl_of(exp_d));
      end
      if (acc) sb_q.push_back(in_data);
      step();
      check("sb_occ", occupancy, sb_q.size());
      check("sb_valid", out_valid, sb_q.size() != 0);
      check("sb_ready", in_ready, sb_q.size() < 2);
      if (sb_q.size() == 0) check("sb_ctrl_idle", out_ctrl, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4 && sb_q.size() != 0; c++) begin
      exp_d = sb_q.pop_front();
      check("sb_drain_data", out_data, exp_d);
      step();
    end
    check("sb_drain_left", sb_q.size(), 0);
    check("sb_drain_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
